lc3_mem_io: RTL and testbench

//  Memory and memory-mapped I/O slave for the LC-3 core. Consumes mar/mdr/memwe, returns memOut.

---
 rtl/lc3_mem_io.sv | 182 ++++++++++++++++++
 tb/tb_lc3_mem_io.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_io.sv
// rtl/lc3_mem_io.sv - LC-3 memory and memory-mapped keyboard/display slave
//
// Purpose:
//   Word RAM plus the LC-3 keyboard (KBSR/KBDR) and display (DSR/DDR)
//   device registers. Display writes are queued in a small TX FIFO that a
//   valid/ready sink drains; keyboard characters arrive on a valid/ready
//   stream and are held in KBDR until the core reads it.
//
// Ports:
//   clk       in   1   rising-edge clock
//   reset_n   in   1   asynchronous active-low reset
//   mar       in   16  word address from core
//   mdr       in   16  write data from core
//   memwe     in   1   write strobe (one cycle, mar/mdr stable)
//   memOut    out  16  read data, combinational from mar
//   kb_valid  in   1   keyboard char offered
//   kb_data   in   8   keyboard char
//   kb_ready  out  1   block can accept a keyboard char
//   tx_valid  out  1   display char available (FIFO not empty)
//   tx_data   out  8   display char at FIFO head
//   tx_ready  in   1   display sink accepts char
//   tx_ovf    out  1   sticky: a DDR write was dropped because FIFO was full

module lc3_mem_io #(
  parameter int    RAM_AW    = 8,
  parameter int    TX_DEPTH  = 4,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mar,
  input  logic [15:0] mdr,
  input  logic        memwe,
  output logic [15:0] memOut,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        kb_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        tx_ovf
);

  localparam logic [15:0] ADDR_KBSR = 16'hFE00;
  localparam logic [15:0] ADDR_KBDR = 16'hFE02;
  localparam logic [15:0] ADDR_DSR  = 16'hFE04;
  localparam logic [15:0] ADDR_DDR  = 16'hFE06;

  localparam int PW = $clog2(TX_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TX_DEPTH);

  // ---------------------------------------------------------------------------
  // Address decode. RAM is selected only when every bit above the index is
  // zero, so addresses beyond the RAM never alias back onto it.
  // ---------------------------------------------------------------------------
  logic ram_sel;
  assign ram_sel = (mar[15:RAM_AW] == '0);

  // ---------------------------------------------------------------------------
  // RAM: synchronous write, asynchronous read, deliberately not reset so its
  // contents survive a mid-run reset.
  // ---------------------------------------------------------------------------
  logic [15:0] mem [0:(2**RAM_AW)-1];

  always_ff @(posedge clk) begin
    if (memwe && ram_sel) begin
      mem[mar[RAM_AW-1:0]] <= mdr;
    end
  end

  // ---------------------------------------------------------------------------
  // Keyboard. The KBDR read is detected as the first edge at which mar sits
  // on KBDR (mar_q remembers the previous address), so a core that holds mar
  // there for several cycles consumes the character only once.
  // ---------------------------------------------------------------------------
  typedef enum logic {KB_EMPTY, KB_FULL} kb_state_t;

  kb_state_t   kb_state;
  logic [7:0]  kbdr;
  logic [15:0] mar_q;
  logic        kb_full;
  logic        kbdr_read;

  assign kb_full   = (kb_state == KB_FULL);
  assign kb_ready  = (kb_state == KB_EMPTY);
  assign kbdr_read = (mar == ADDR_KBDR) && (mar_q != ADDR_KBDR);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kb_state <= KB_EMPTY;
      kbdr     <= 8'h00;
      mar_q    <= 16'h0000;
    end else begin
      mar_q <= mar;
      case (kb_state)
        KB_EMPTY: begin
          if (kb_valid) begin
            kbdr     <= kb_data;
            kb_state <= KB_FULL;
          end
        end
        KB_FULL: begin
          // The core captures the old kbdr at this same edge; a new char
          // can only be accepted from the next edge on.
          if (kbdr_read) begin
            kb_state <= KB_EMPTY;
          end
        end
        default: kb_state <= KB_EMPTY;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // TX FIFO. A DDR write into a full FIFO is still accepted when the sink
  // pops at the same edge, because the pop frees the slot being written.
  // ---------------------------------------------------------------------------
  logic [7:0]    tx_buf [0:TX_DEPTH-1];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] tx_count;
  logic          ddr_wr;
  logic          pop;
  logic          push;
  logic          not_full;

  assign not_full = (tx_count < DEPTH_C);
  assign tx_valid = (tx_count != '0);
  assign tx_data  = tx_valid ? tx_buf[rd_ptr] : 8'h00;
  assign ddr_wr   = memwe && (mar == ADDR_DDR);
  assign pop      = tx_valid && tx_ready;
  assign push     = ddr_wr && (not_full || pop);

  always_ff @(posedge clk) begin
    if (push) begin
      tx_buf[wr_ptr] <= mdr[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tx_count <= '0;
      tx_ovf   <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (push && !pop) begin
        tx_count <= tx_count + 1'b1;
      end else if (pop && !push) begin
        tx_count <= tx_count - 1'b1;
      end
      if (ddr_wr && !push) begin
        tx_ovf <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux (zero latency).
  // ---------------------------------------------------------------------------
  always_comb begin
    memOut = 16'h0000;
    if (ram_sel) begin
      memOut = mem[mar[RAM_AW-1:0]];
    end else begin
      case (mar)
        ADDR_KBSR: memOut = {kb_full, 15'b0};
        ADDR_KBDR: memOut = {8'h00, kbdr};
        ADDR_DSR:  memOut = {not_full, 15'b0};
        default:   memOut = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_mem_io.sv
// tb/tb_lc3_mem_io.sv - self-checking bench for lc3_mem_io

module tb_lc3_mem_io;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        memwe;
  logic [15:0] memOut;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        kb_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        tx_ovf;

  lc3_mem_io #(.RAM_AW(8), .TX_DEPTH(4), .INIT_FILE("")) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .mar      (mar),
    .mdr      (mdr),
    .memwe    (memwe),
    .memOut   (memOut),
    .kb_valid (kb_valid),
    .kb_data  (kb_data),
    .kb_ready (kb_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .tx_ovf   (tx_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        we;
    logic        kbv;
    logic [7:0]  kbd;
    logic        txr;
    logic [15:0] e_mem;
    logic        e_kbr;
    logic        e_txv;
    logic [7:0]  e_txd;
    logic        e_ovf;
  } vec_t;

  vec_t vt[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input logic [15:0] a, input logic [15:0] d, input logic we,
                     input logic kbv, input logic [7:0] kbd, input logic txr,
                     input logic [15:0] e_mem, input logic e_kbr, input logic e_txv,
                     input logic [7:0] e_txd, input logic e_ovf);
    vec_t v;
    v.mar = a; v.mdr = d; v.we = we; v.kbv = kbv; v.kbd = kbd; v.txr = txr;
    v.e_mem = e_mem; v.e_kbr = e_kbr; v.e_txv = e_txv; v.e_txd = e_txd; v.e_ovf = e_ovf;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we,
                      input logic kbv, input logic [7:0] kbd, input logic txr);
    @(negedge clk);
    mar = a; mdr = d; memwe = we; kb_valid = kbv; kb_data = kbd; tx_ready = txr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; mar = 16'h0000; mdr = 16'h0000; memwe = 1'b0;
    kb_valid = 1'b0; kb_data = 8'h00; tx_ready = 1'b0;

    //       mar      mdr      we kbv kbd    txr  memOut   kbr txv txd    ovf
    // RAM
    add(16'h0010, 16'h1234, 1, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 0);
    add(16'h0000, 16'h5555, 1, 0, 8'h00, 0, 16'h5555, 1, 0, 8'h00, 0);
    add(16'h00FF, 16'hA5A5, 1, 0, 8'h00, 0, 16'hA5A5, 1, 0, 8'h00, 0);
    add(16'h0100, 16'hBEEF, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
    add(16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h5555, 1, 0, 8'h00, 0);
    add(16'h0010, 16'h0000, 0, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 0);
    add(16'h00FF, 16'h0000, 0, 0, 8'h00, 0, 16'hA5A5, 1, 0, 8'h00, 0);
    // Keyboard
    add(16'hFE00, 16'h0000, 0, 1, 8'h41, 0, 16'h8000, 0, 0, 8'h00, 0);
    add(16'hFE00, 16'h0000, 0, 1, 8'h42, 0, 16'h8000, 0, 0, 8'h00, 0);
    add(16'h0010, 16'h0000, 0, 0, 8'h00, 0, 16'h1234, 0, 0, 8'h00, 0);
    add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0041, 1, 0, 8'h00, 0);
    add(16'hFE02, 16'h0000, 0, 1, 8'h43, 0, 16'h0043, 0, 0, 8'h00, 0);
    add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0043, 0, 0, 8'h00, 0);
    add(16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h8000, 0, 0, 8'h00, 0);
    add(16'hFE02, 16'h0000, 0, 0, 8'h00, 0, 16'h0043, 1, 0, 8'h00, 0);
    add(16'hFE00, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 0);
    // TX fill, overflow, push+pop while full, drain
    add(16'hFE06, 16'h0061, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h61, 0);
    add(16'hFE06, 16'h0062, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h61, 0);
    add(16'hFE06, 16'h0063, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h61, 0);
    add(16'hFE06, 16'hAB64, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h61, 0);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h61, 0);
    add(16'hFE06, 16'h0065, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h61, 1);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h61, 1);
    add(16'hFE06, 16'h0065, 1, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h62, 1);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h62, 1);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8000, 1, 1, 8'h63, 1);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8000, 1, 1, 8'h64, 1);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8000, 1, 1, 8'h65, 1);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8000, 1, 0, 8'h00, 1);
    // push+pop at count=1, push into empty with sink ready
    add(16'hFE06, 16'h0070, 1, 0, 8'h00, 0, 16'h0000, 1, 1, 8'h70, 1);
    add(16'hFE06, 16'h0071, 1, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h71, 1);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8000, 1, 0, 8'h00, 1);
    add(16'hFE06, 16'h0072, 1, 0, 8'h00, 1, 16'h0000, 1, 1, 8'h72, 1);
    add(16'hFE04, 16'h0000, 0, 0, 8'h00, 1, 16'h8000, 1, 0, 8'h00, 1);
    // Ignored writes and unmapped reads
    add(16'hFE00, 16'hFFFF, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
    add(16'hFE04, 16'h0000, 1, 0, 8'h00, 0, 16'h8000, 1, 0, 8'h00, 1);
    add(16'h8000, 16'h1111, 1, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);
    add(16'hFE02, 16'h00FF, 1, 0, 8'h00, 0, 16'h0043, 1, 0, 8'h00, 1);
    add(16'h0000, 16'h0000, 0, 0, 8'h00, 0, 16'h5555, 1, 0, 8'h00, 1);
    add(16'h0010, 16'h0000, 0, 0, 8'h00, 0, 16'h1234, 1, 0, 8'h00, 1);
    add(16'h00FF, 16'h0000, 0, 0, 8'h00, 0, 16'hA5A5, 1, 0, 8'h00, 1);
    add(16'hFFFF, 16'h0000, 0, 0, 8'h00, 0, 16'h0000, 1, 0, 8'h00, 1);

    // Reset state
    #12;
    chk("rst_kb_ready", {15'b0, kb_ready}, 16'h0001);
    chk("rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("rst_tx_data",  {8'h00, tx_data},  16'h0000);
    chk("rst_tx_ovf",   {15'b0, tx_ovf},   16'h0000);
    mar = 16'hFE04; #1;
    chk("rst_dsr", memOut, 16'h8000);
    mar = 16'hFE02; #1;
    chk("rst_kbdr", memOut, 16'h0000);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].mar, vt[i].mdr, vt[i].we, vt[i].kbv, vt[i].kbd, vt[i].txr);
      n_vec++;
      if (memOut !== vt[i].e_mem || kb_ready !== vt[i].e_kbr || tx_valid !== vt[i].e_txv ||
          tx_data !== vt[i].e_txd || tx_ovf !== vt[i].e_ovf) begin
        n_bad++;
        $display("FAIL vec%0d: got memOut=%h kb_ready=%b tx_valid=%b tx_data=%h tx_ovf=%b, expected %h %b %b %h %b",
                 i, memOut, kb_ready, tx_valid, tx_data, tx_ovf,
                 vt[i].e_mem, vt[i].e_kbr, vt[i].e_txv, vt[i].e_txd, vt[i].e_ovf);
      end
    end

    // Zero-latency read: memOut follows mar between edges
    @(negedge clk);
    memwe = 1'b0; tx_ready = 1'b0; mar = 16'h0010; #1;
    chk("comb_read_ram", memOut, 16'h1234);
    mar = 16'hFE02; #1;
    chk("comb_read_kbdr", memOut, 16'h0043);

    // Mid-run reset with two chars queued and a keyboard char held
    step(16'hFE06, 16'h0081, 1, 0, 8'h00, 0);
    step(16'hFE06, 16'h0082, 1, 0, 8'h00, 0);
    step(16'h0000, 16'h0000, 0, 1, 8'h55, 0);
    @(negedge clk);
    kb_valid = 1'b0; mar = 16'hFE02;
    #1;
    chk("pre_rst_tx_valid", {15'b0, tx_valid}, 16'h0001);
    chk("pre_rst_kb_ready", {15'b0, kb_ready}, 16'h0000);
    chk("pre_rst_kbdr",     memOut,            16'h0055);
    reset_n = 1'b0;
    #1;
    chk("midrst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("midrst_tx_data",  {8'h00, tx_data},  16'h0000);
    chk("midrst_kb_ready", {15'b0, kb_ready}, 16'h0001);
    chk("midrst_tx_ovf",   {15'b0, tx_ovf},   16'h0000);
    chk("midrst_kbdr",     memOut,            16'h0000);
    mar = 16'h0010; #1;
    chk("midrst_ram_kept", memOut, 16'h1234);
    reset_n = 1'b1;
    step(16'hFE04, 16'h0000, 0, 0, 8'h00, 1);
    chk("post_rst_dsr",      memOut,            16'h8000);
    chk("post_rst_tx_valid", {15'b0, tx_valid}, 16'h0000);
    chk("post_rst_kb_ready", {15'b0, kb_ready}, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
